// File: rtl/data_memory_wb.sv
// Single-ported data memory with byte-enable writes, a one-entry posted write
// buffer and read forwarding from it. Reads return a registered result one cycle later.
module data_memory_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    localparam int BE_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              re,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] wrt_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              stall
);

    logic [DATA_W-1:0] mem [0:2**ADDR_W-1];

    logic              wb_valid_reg, wb_valid_next;
    logic [ADDR_W-1:0] wb_addr_reg,  wb_addr_next;
    logic [DATA_W-1:0] wb_data_reg,  wb_data_next;
    logic [BE_W-1:0]   wb_be_reg,    wb_be_next;
    logic [DATA_W-1:0] rd_data_reg,  rd_data_next;
    logic              rd_valid_reg, rd_valid_next;
    logic              pre_read_reg;
    logic [DATA_W-1:0] pend_data_reg;

    logic              hit;
    logic [DATA_W-1:0] mem_rd;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] merge_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_wbe;

    // The stall edge already performs the colliding read (the port is free
    // because the buffer does not drain); the held request then completes
    // on the next edge, where the port drains the buffer instead.
    assign stall  = wb_valid_reg & re & we & ~pre_read_reg;
    assign hit    = wb_valid_reg && (addr == wb_addr_reg);
    assign mem_rd = mem[addr];

    generate
        for (genvar gi = 0; gi < BE_W; gi++) begin : g_byte
            assign rd_word[gi*8 +: 8]    = (hit && wb_be_reg[gi]) ? wb_data_reg[gi*8 +: 8]
                                                                  : mem_rd[gi*8 +: 8];
            assign merge_data[gi*8 +: 8] = be[gi] ? wrt_data[gi*8 +: 8]
                                                  : wb_data_reg[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        mem_we        = 1'b0;
        mem_waddr     = wb_addr_reg;
        mem_wdata     = wb_data_reg;
        mem_wbe       = wb_be_reg;
        wb_valid_next = wb_valid_reg;
        wb_addr_next  = wb_addr_reg;
        wb_data_next  = wb_data_reg;
        wb_be_next    = wb_be_reg;
        rd_data_next  = rd_data_reg;
        rd_valid_next = 1'b0;

        if (!stall) begin
            if (re) begin
                rd_valid_next = 1'b1;
                rd_data_next  = (pre_read_reg && we) ? pend_data_reg : rd_word;
            end

            if (we) begin
                if (wb_valid_reg && hit) begin
                    wb_data_next = merge_data;
                    wb_be_next   = wb_be_reg | be;
                end else if (wb_valid_reg || re) begin
                    // Drain whatever is parked (if anything) and park the new write.
                    mem_we        = wb_valid_reg;
                    wb_valid_next = 1'b1;
                    wb_addr_next  = addr;
                    wb_data_next  = wrt_data;
                    wb_be_next    = be;
                end else begin
                    mem_we    = 1'b1;
                    mem_waddr = addr;
                    mem_wdata = wrt_data;
                    mem_wbe   = be;
                end
            end else if (!re && wb_valid_reg) begin
                mem_we        = 1'b1;
                wb_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_reg  <= 1'b0;
            wb_addr_reg   <= '0;
            wb_data_reg   <= '0;
            wb_be_reg     <= '0;
            rd_data_reg   <= '0;
            rd_valid_reg  <= 1'b0;
            pre_read_reg  <= 1'b0;
            pend_data_reg <= '0;
        end else begin
            wb_valid_reg  <= wb_valid_next;
            wb_addr_reg   <= wb_addr_next;
            wb_data_reg   <= wb_data_next;
            wb_be_reg     <= wb_be_next;
            rd_data_reg   <= rd_data_next;
            rd_valid_reg  <= rd_valid_next;
            pre_read_reg  <= stall;
            if (stall) begin
                pend_data_reg <= rd_word;
            end
        end
    end

    // Array contents are intentionally not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (mem_we && mem_wbe[i]) begin
                mem[mem_waddr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
            end
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;

endmodule
